enet_tx_sched: RTL and testbench
================================

ENET_TX_SCHED -- requirements
Module: enet_tx_sched

Interface
REQ-001 SHALL have parameter NLP_PERIOD, default 320000, idle clocks between link pulses (16 ms at 20 MHz).
REQ-002 SHALL have parameter IFG_CYCLES, default 192, interframe gap in clocks (9.6 us).
REQ-003 SHALL have parameter MAX_LEN, default 1526, maximum frame length in bytes, preamble and SFD included.
REQ-004 SHALL use one clock and a synchronous, active-high reset: clk_20mhz  in  1  sole clock; rst_i  in  1  synchronous active-high reset.
REQ-005 SHALL have requester ports, N=0,1: reqN  in  1  frame pending (level); lenN  in  11  frame byte count; gntN  out  1  grant pulse; doneN  out  1  frame-complete pulse.
REQ-006 SHALL have byte fetch ports: byte_rd  out  1  fetch strobe; byte_src  out  1  granted requester index; byte_in0, byte_in1  in  8  requester byte data.
REQ-007 SHALL have encoder ports: enc_byte  out  8  byte to serialize; enc_valid  out  1  byte valid; enc_ready  in  1  encoder accepts byte; enc_last  out  1  final byte of frame; enc_busy  in  1  encoder emitting bits or ETD; nlp  out  1  link-pulse request pulse.

Function
REQ-008 SHALL implement the states IDLE, GRANT, FETCH, LOAD, PRESENT, DRAIN and IFG.
REQ-009 SHALL, in IDLE with enc_busy low and at least one reqN high, pick a winner round-robin; last-granted pointer resets to 1, so requester 0 wins the first tie.
REQ-010 SHALL, in GRANT, pulse gntN for 1 cycle, latch lenN, set byte_src=N, and clamp lengths above MAX_LEN to MAX_LEN.
REQ-011 SHALL, on latched length 0, pulse doneN in the cycle after the gntN pulse, transmit nothing, skip IFG and return to IDLE.
REQ-012 SHALL pulse byte_rd for 1 cycle in FETCH; the selected byte_inN is valid exactly one cycle later, and LOAD registers it into enc_byte.
REQ-013 SHALL hold enc_valid high and enc_byte stable from LOAD until the cycle enc_valid&enc_ready are both high.
REQ-014 SHALL, on that handshake, decrement the remaining count and go to FETCH if it is still above 0, otherwise to DRAIN.
REQ-015 SHALL drive enc_last high together with enc_valid for the final byte only.
REQ-016 SHALL, in DRAIN, wait for enc_busy low, then pulse doneN for 1 cycle and enter IFG.
REQ-017 SHALL stay in IFG for exactly IFG_CYCLES clocks, then return to IDLE; requests are not sampled during IFG.
REQ-018 SHALL ignore deassertion of reqN after grant; the frame completes with the latched length.
REQ-019 SHALL, via the NLP timer, count clocks only in IDLE with enc_busy low; any other state clears it.
REQ-020 SHALL, when the NLP timer reaches NLP_PERIOD-1, pulse nlp for 1 cycle and clear the timer.
REQ-021 SHALL give nlp priority over a request arriving in the same cycle; that grant is deferred until enc_busy is low again.
REQ-022 SHALL keep gnt0/gnt1, done0/done1, byte_rd and nlp mutually exclusive in any cycle.

Reset
REQ-023 SHALL, on rst_i high at a clock edge, enter IDLE, set the RR pointer=1, and clear the NLP timer, IFG counter and remaining count.
REQ-024 SHALL hold all outputs at 0 on reset: gntN, doneN, byte_rd, byte_src, enc_byte, enc_valid, enc_last and nlp.
REQ-025 SHALL, on reset mid-frame, abandon the frame with no doneN pulse; the requester re-requests.

Structure
REQ-026 SHALL place the state enum, NLP_PERIOD, IFG_CYCLES and MAX_LEN defaults in shared package enet_pkg.
REQ-027 SHALL implement the NLP timer as sub-module enet_nlp_timer (inputs count_en, clear; output expire pulse).

Verification
REQ-028 SHALL cover: req0 with len0=3, encoder ready every 16 clks -> gnt0 once, 3 byte_rd, enc_last on 3rd byte, done0 after enc_busy low, no gnt for 192 clks.
REQ-029 SHALL cover: req0 and req1 both held, len=2 each -> grants alternate 0,1,0,1, each separated by >=192 idle clks after done.
REQ-030 SHALL cover: no requests, NLP_PERIOD=100 -> nlp pulses every 100 clks; req1 asserted in an expiry cycle -> nlp first, gnt1 after enc_busy low.
REQ-031 SHALL cover: len1=0 -> gnt1 then done1 next cycle, no byte_rd, no enc_valid, next grant possible immediately.
REQ-032 SHALL cover: len0=2000 -> exactly 1526 bytes presented; rst_i asserted mid-frame -> all outputs 0 next cycle, no done0.

Source files
------------

// File: rtl/enet_pkg.sv
// Shared state encoding, default timing constants and length clamp for the Ethernet TX scheduler.
package enet_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GRANT,
        ST_FETCH,
        ST_LOAD,
        ST_PRESENT,
        ST_DRAIN,
        ST_IFG
    } tx_state_t;

    localparam int NLP_PERIOD_DEF = 320000;
    localparam int IFG_CYCLES_DEF = 192;
    localparam int MAX_LEN_DEF    = 1526;

    function automatic logic [10:0] clamp_len(input logic [10:0] len, input logic [10:0] max_len);
        return (len > max_len) ? max_len : len;
    endfunction

endpackage

// File: rtl/enet_nlp_timer.sv
// Idle-time counter for normal link pulses: expire is combinational in the PERIOD-th counted clock.
// No backpressure; count_en stalls the count, clear (or expiry) restarts it from zero.
module enet_nlp_timer
    import enet_pkg::*;
#(
    parameter int PERIOD = NLP_PERIOD_DEF
) (
    input  logic clk_20mhz,
    input  logic rst_i,
    input  logic count_en,
    input  logic clear,
    output logic expire
);

    localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    logic [CW-1:0] cnt_q;

    assign expire = count_en && (cnt_q == CW'(PERIOD - 1));

    always_ff @(posedge clk_20mhz) begin
        if (rst_i || clear || expire) begin
            cnt_q <= '0;
        end else if (count_en) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/enet_tx_sched.sv
// Round-robin two-requester frame scheduler feeding a byte-wide 10BASE-T encoder, with IFG and NLP timing.
// Grant one clock after IDLE sees a request; one byte per FETCH/LOAD/PRESENT pass, stalled by enc_ready and enc_busy.
module enet_tx_sched
    import enet_pkg::*;
#(
    parameter int NLP_PERIOD = NLP_PERIOD_DEF,
    parameter int IFG_CYCLES = IFG_CYCLES_DEF,
    parameter int MAX_LEN    = MAX_LEN_DEF
) (
    input  logic        clk_20mhz,
    input  logic        rst_i,
    input  logic        req0,
    input  logic [10:0] len0,
    output logic        gnt0,
    output logic        done0,
    input  logic        req1,
    input  logic [10:0] len1,
    output logic        gnt1,
    output logic        done1,
    output logic        byte_rd,
    output logic        byte_src,
    input  logic [7:0]  byte_in0,
    input  logic [7:0]  byte_in1,
    output logic [7:0]  enc_byte,
    output logic        enc_valid,
    input  logic        enc_ready,
    output logic        enc_last,
    input  logic        enc_busy,
    output logic        nlp
);

    localparam int IW = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;

    tx_state_t      state_q, state_d;
    logic           cur_q;
    logic           last_q;
    logic [10:0]    rem_q;
    logic [IW-1:0]  ifg_q;
    logic [7:0]     byte_q;
    logic           zdone_q;

    logic           win;
    logic [10:0]    len_clamped;
    logic [7:0]     byte_sel;
    logic           idle_free;
    logic           nlp_exp;
    logic           done_any;

    assign idle_free   = (state_q == ST_IDLE) && !enc_busy;
    assign len_clamped = clamp_len(cur_q ? len1 : len0, 11'(MAX_LEN));
    assign byte_sel    = cur_q ? byte_in1 : byte_in0;
    assign win         = (req0 && req1) ? !last_q : req1;

    enet_nlp_timer #(
        .PERIOD   (NLP_PERIOD)
    ) u_nlp_timer (
        .clk_20mhz(clk_20mhz),
        .rst_i    (rst_i),
        .count_en (idle_free),
        .clear    (state_q != ST_IDLE),
        .expire   (nlp_exp)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (idle_free && !nlp_exp && (req0 || req1)) state_d = ST_GRANT;
            ST_GRANT:   state_d = (len_clamped == 11'd0) ? ST_IDLE : ST_FETCH;
            ST_FETCH:   state_d = ST_LOAD;
            ST_LOAD:    state_d = ST_PRESENT;
            ST_PRESENT: if (enc_ready) state_d = (rem_q > 11'd1) ? ST_FETCH : ST_DRAIN;
            ST_DRAIN:   if (!enc_busy) state_d = ST_IFG;
            ST_IFG:     if (ifg_q == IW'(IFG_CYCLES - 1)) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_20mhz) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cur_q   <= 1'b0;
            last_q  <= 1'b1;
            rem_q   <= '0;
            ifg_q   <= '0;
            byte_q  <= '0;
            zdone_q <= 1'b0;
        end else begin
            state_q <= state_d;
            zdone_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (state_d == ST_GRANT) begin
                        cur_q  <= win;
                        last_q <= win;
                    end
                end
                ST_GRANT: begin
                    rem_q   <= len_clamped;
                    zdone_q <= (len_clamped == 11'd0);
                end
                ST_LOAD:    byte_q <= byte_sel;
                ST_PRESENT: if (enc_ready) rem_q <= rem_q - 11'd1;
                ST_IFG:     ifg_q <= (ifg_q == IW'(IFG_CYCLES - 1)) ? '0 : ifg_q + IW'(1);
                default: ;
            endcase
        end
    end

    // Zero-length completion lands in the IDLE cycle after GRANT; the NLP timer was cleared in GRANT,
    // so it cannot expire there and the pulses stay exclusive.
    assign done_any  = ((state_q == ST_DRAIN) && !enc_busy) || zdone_q;
    assign gnt0      = (state_q == ST_GRANT) && !cur_q;
    assign gnt1      = (state_q == ST_GRANT) && cur_q;
    assign done0     = done_any && !cur_q;
    assign done1     = done_any && cur_q;
    assign byte_rd   = (state_q == ST_FETCH);
    assign byte_src  = cur_q;
    assign enc_byte  = byte_q;
    assign enc_valid = (state_q == ST_PRESENT);
    assign enc_last  = (state_q == ST_PRESENT) && (rem_q == 11'd1);
    assign nlp       = nlp_exp;

endmodule

// File: tb/tb_enet_tx_sched.sv
// Directed bench for enet_tx_sched: behavioural encoder/byte-source model plus per-feature check tasks.
module tb_enet_tx_sched;

    logic        clk_20mhz = 1'b0;
    logic        rst_i, req0, req1;
    logic [10:0] len0, len1;
    logic        gnt0, gnt1, done0, done1, byte_rd, byte_src;
    logic [7:0]  byte_in0, byte_in1, enc_byte;
    logic        enc_valid, enc_ready, enc_last, enc_busy, nlp;

    int total = 0;
    int bad = 0;
    int nlp_busy_len = 0;
    int n_excl = 0;

    always #25 clk_20mhz = ~clk_20mhz;

    enet_tx_sched #(
        .NLP_PERIOD(100),
        .IFG_CYCLES(192),
        .MAX_LEN   (1526)
    ) dut (
        .clk_20mhz(clk_20mhz),
        .rst_i    (rst_i),
        .req0     (req0),
        .len0     (len0),
        .gnt0     (gnt0),
        .done0    (done0),
        .req1     (req1),
        .len1     (len1),
        .gnt1     (gnt1),
        .done1    (done1),
        .byte_rd  (byte_rd),
        .byte_src (byte_src),
        .byte_in0 (byte_in0),
        .byte_in1 (byte_in1),
        .enc_byte (enc_byte),
        .enc_valid(enc_valid),
        .enc_ready(enc_ready),
        .enc_last (enc_last),
        .enc_busy (enc_busy),
        .nlp      (nlp)
    );

    // Encoder: ready one clock in 16, busy 16 clocks per byte (20 after the last), nlp_busy_len after a link pulse.
    // Byte source: answers byte_rd one clock later with 8'h10+k (req0) or 8'hA0+k (req1), 8'hEE otherwise.
    initial begin : enc_model
        int busy_cnt, rdy_div, idx0, idx1;
        logic hs, lst, np, rd, src;
        busy_cnt = 0; rdy_div = 0; idx0 = 0; idx1 = 0;
        enc_ready = 1'b0; enc_busy = 1'b0; byte_in0 = 8'hEE; byte_in1 = 8'hEE;
        forever begin
            @(negedge clk_20mhz);
            hs  = enc_valid && enc_ready && !rst_i;
            lst = enc_last;
            np  = nlp && !rst_i;
            rd  = byte_rd && !rst_i;
            src = byte_src;
            if (gnt0) idx0 = 0;
            if (gnt1) idx1 = 0;
            if ($countones({gnt0, gnt1, done0, done1, byte_rd, nlp}) > 1) n_excl++;
            @(posedge clk_20mhz);
            #1;
            if (rst_i) busy_cnt = 0;
            else if (hs) busy_cnt = lst ? 20 : 16;
            else if (np) busy_cnt = nlp_busy_len;
            else if (busy_cnt > 0) busy_cnt--;
            enc_busy = (busy_cnt > 0);
            rdy_div = (rdy_div == 15) ? 0 : rdy_div + 1;
            enc_ready = (rdy_div == 0);
            byte_in0 = 8'hEE;
            byte_in1 = 8'hEE;
            if (rd && !src) begin byte_in0 = 8'h10 + 8'(idx0); idx0++; end
            if (rd && src)  begin byte_in1 = 8'hA0 + 8'(idx1); idx1++; end
        end
    end

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (3) @(negedge clk_20mhz);
        total++;
        if ({gnt0, gnt1, done0, done1, byte_rd, nlp} !== 6'b0) begin
            bad++; $display("FAIL reset_pulses: got=%b exp=000000", {gnt0, gnt1, done0, done1, byte_rd, nlp});
        end
        total++;
        if (byte_src !== 1'b0) begin bad++; $display("FAIL reset_byte_src: got=%b exp=0", byte_src); end
        total++;
        if (enc_byte !== 8'h00) begin bad++; $display("FAIL reset_enc_byte: got=%h exp=00", enc_byte); end
        total++;
        if ({enc_valid, enc_last} !== 2'b00) begin
            bad++; $display("FAIL reset_valid_last: got=%b exp=00", {enc_valid, enc_last});
        end
        rst_i = 1'b0;
    endtask

    task automatic test_nlp_period();
        int n;
        nlp_busy_len = 0;
        n = 0;
        do begin @(negedge clk_20mhz); n++; end while (!nlp && n < 300);
        total++;
        if (nlp !== 1'b1 || n != 99) begin bad++; $display("FAIL nlp_first: got cycle=%0d exp=99", n); end
        for (int k = 0; k < 2; k++) begin
            n = 0;
            do begin @(negedge clk_20mhz); n++; end while (!nlp && n < 300);
            total++;
            if (nlp !== 1'b1 || n != 100) begin bad++; $display("FAIL nlp_interval%0d: got=%0d exp=100", k, n); end
        end
    endtask

    task automatic test_nlp_priority();
        int n;
        nlp_busy_len = 8;
        len1 = 11'd0;
        n = 0;
        do begin @(negedge clk_20mhz); n++; end while (!nlp && n < 300);
        req1 = 1'b1;
        n = 0;
        do begin @(negedge clk_20mhz); n++; end while (!gnt0 && !gnt1 && n < 60);
        total++;
        if (gnt1 !== 1'b1 || n != 10) begin
            bad++; $display("FAIL nlp_prio_gnt: got gnt1=%b after=%0d exp gnt1=1 after=10", gnt1, n);
        end
        total++;
        if (byte_src !== 1'b1) begin bad++; $display("FAIL nlp_prio_src: got=%b exp=1", byte_src); end
        req1 = 1'b0;
        @(negedge clk_20mhz);
        total++;
        if ({gnt1, done1} !== 2'b01) begin bad++; $display("FAIL nlp_prio_done: got gnt1,done1=%b exp=01", {gnt1, done1}); end
    endtask

    task automatic test_zero_len();
        int n, seen;
        len1 = 11'd0;
        req1 = 1'b1;
        seen = 0;
        n = 0;
        do begin @(negedge clk_20mhz); n++; end while (!gnt1 && n < 300);
        total++;
        if (gnt1 !== 1'b1) begin bad++; $display("FAIL zero_gnt: got gnt1=%b exp=1", gnt1); end
        @(negedge clk_20mhz);
        if (byte_rd || enc_valid) seen++;
        total++;
        if ({gnt1, done1} !== 2'b01) begin bad++; $display("FAIL zero_done: got gnt1,done1=%b exp=01", {gnt1, done1}); end
        @(negedge clk_20mhz);
        if (byte_rd || enc_valid) seen++;
        total++;
        if (gnt1 !== 1'b1) begin bad++; $display("FAIL zero_regrant: got gnt1=%b exp=1", gnt1); end
        req1 = 1'b0;
        @(negedge clk_20mhz);
        if (byte_rd || enc_valid) seen++;
        total++;
        if (done1 !== 1'b1) begin bad++; $display("FAIL zero_done2: got done1=%b exp=1", done1); end
        repeat (4) begin @(negedge clk_20mhz); if (byte_rd || enc_valid) seen++; end
        total++;
        if (seen != 0) begin bad++; $display("FAIL zero_no_bytes: got rd/valid cycles=%0d exp=0", seen); end
    endtask

    task automatic test_basic();
        int n, nrd, nhs, nlast, lastpos, extra, unstable, lastbad;
        logic [7:0] hsb [3];
        logic [7:0] exp_b [3];
        logic [7:0] held;
        logic prev_v, busy_at_done;
        exp_b[0] = 8'h10; exp_b[1] = 8'h11; exp_b[2] = 8'h12;
        len0 = 11'd3;
        req0 = 1'b1;
        n = 0;
        do begin @(negedge clk_20mhz); n++; end while (!gnt0 && n < 300);
        total++;
        if (gnt0 !== 1'b1 || byte_src !== 1'b0) begin
            bad++; $display("FAIL basic_gnt: got gnt0=%b src=%b exp gnt0=1 src=0", gnt0, byte_src);
        end
        nrd = 0; nhs = 0; nlast = 0; lastpos = -1; extra = 0; unstable = 0; lastbad = 0;
        held = 8'h00; prev_v = 1'b0;
        for (int i = 0; i < 3; i++) hsb[i] = 8'h00;
        n = 0;
        do begin
            @(negedge clk_20mhz); n++;
            if (byte_rd) nrd++;
            if (gnt0 || gnt1) extra++;
            if (enc_last && !enc_valid) lastbad++;
            if (enc_valid && prev_v && enc_byte !== held) unstable++;
            held = enc_byte;
            prev_v = enc_valid;
            if (enc_valid && enc_ready) begin
                if (nhs < 3) hsb[nhs] = enc_byte;
                if (enc_last) begin nlast++; lastpos = nhs; end
                nhs++;
            end
        end while (!done0 && n < 2000);
        busy_at_done = enc_busy;
        total++;
        if (done0 !== 1'b1 || done1 !== 1'b0) begin bad++; $display("FAIL basic_done: got done0=%b done1=%b exp 1 0", done0, done1); end
        total++;
        if (busy_at_done !== 1'b0) begin bad++; $display("FAIL basic_done_busy: got enc_busy=%b exp=0", busy_at_done); end
        total++;
        if (nrd != 3) begin bad++; $display("FAIL basic_byte_rd: got=%0d exp=3", nrd); end
        total++;
        if (nhs != 3) begin bad++; $display("FAIL basic_bytes: got=%0d exp=3", nhs); end
        for (int i = 0; i < 3; i++) begin
            total++;
            if (hsb[i] !== exp_b[i]) begin bad++; $display("FAIL basic_byte%0d: got=%h exp=%h", i, hsb[i], exp_b[i]); end
        end
        total++;
        if (nlast != 1 || lastpos != 2) begin bad++; $display("FAIL basic_last: got count=%0d pos=%0d exp 1 2", nlast, lastpos); end
        total++;
        if (lastbad != 0 || unstable != 0) begin
            bad++; $display("FAIL basic_hold: got last_wo_valid=%0d unstable=%0d exp 0 0", lastbad, unstable);
        end
        total++;
        if (extra != 0) begin bad++; $display("FAIL basic_extra_gnt: got=%0d exp=0", extra); end
        n = 0;
        do begin @(negedge clk_20mhz); n++; end while (!gnt0 && !gnt1 && n < 400);
        total++;
        if (gnt0 !== 1'b1 || n != 194) begin bad++; $display("FAIL basic_ifg_gap: got gnt0=%b gap=%0d exp 1 194", gnt0, n); end
        req0 = 1'b0;
        nrd = 0; nhs = 0;
        n = 0;
        do begin
            @(negedge clk_20mhz); n++;
            if (byte_rd) nrd++;
            if (enc_valid && enc_ready) nhs++;
        end while (!done0 && n < 2000);
        total++;
        if (done0 !== 1'b1 || nrd != 3 || nhs != 3) begin
            bad++; $display("FAIL basic_deassert: got done0=%b rd=%0d hs=%0d exp 1 3 3", done0, nrd, nhs);
        end
    endtask

    task automatic test_rr();
        int n, src;
        rst_i = 1'b1;
        repeat (2) @(negedge clk_20mhz);
        rst_i = 1'b0;
        len0 = 11'd2; len1 = 11'd2;
        req0 = 1'b1; req1 = 1'b1;
        for (int g = 0; g < 4; g++) begin
            n = 0;
            do begin @(negedge clk_20mhz); n++; end while (!gnt0 && !gnt1 && n < 600);
            src = gnt1 ? 1 : 0;
            total++;
            if (!(gnt0 || gnt1) || src != g % 2) begin
                bad++; $display("FAIL rr_order%0d: got gnt0=%b gnt1=%b exp src=%0d", g, gnt0, gnt1, g % 2);
            end
            if (g > 0) begin
                total++;
                if (n != 194) begin bad++; $display("FAIL rr_gap%0d: got=%0d exp=194", g, n); end
            end
            if (g == 3) begin req0 = 1'b0; req1 = 1'b0; end
            n = 0;
            do begin @(negedge clk_20mhz); n++; end while (!done0 && !done1 && n < 600);
            total++;
            if ({done1, done0} !== ((g % 2 == 1) ? 2'b10 : 2'b01)) begin
                bad++; $display("FAIL rr_done%0d: got done1,done0=%b exp src=%0d", g, {done1, done0}, g % 2);
            end
        end
    endtask

    task automatic test_maxlen_reset();
        int n, nhs, nlast, lastpos, late;
        len0 = 11'd2000;
        req0 = 1'b1;
        n = 0;
        do begin @(negedge clk_20mhz); n++; end while (!gnt0 && n < 400);
        total++;
        if (gnt0 !== 1'b1) begin bad++; $display("FAIL max_gnt: got gnt0=%b exp=1", gnt0); end
        req0 = 1'b0;
        nhs = 0; nlast = 0; lastpos = -1;
        n = 0;
        do begin
            @(negedge clk_20mhz); n++;
            if (enc_valid && enc_ready) begin
                if (enc_last) begin nlast++; lastpos = nhs; end
                nhs++;
            end
        end while (!done0 && n < 30000);
        total++;
        if (done0 !== 1'b1 || nhs != 1526) begin bad++; $display("FAIL max_bytes: got done0=%b bytes=%0d exp 1 1526", done0, nhs); end
        total++;
        if (nlast != 1 || lastpos != 1525) begin bad++; $display("FAIL max_last: got count=%0d pos=%0d exp 1 1525", nlast, lastpos); end
        len1 = 11'd5;
        req1 = 1'b1;
        n = 0;
        do begin @(negedge clk_20mhz); n++; end while (!gnt1 && n < 400);
        total++;
        if (gnt1 !== 1'b1) begin bad++; $display("FAIL midrst_gnt: got gnt1=%b exp=1", gnt1); end
        req1 = 1'b0;
        repeat (40) @(negedge clk_20mhz);
        rst_i = 1'b1;
        @(negedge clk_20mhz);
        total++;
        if ({gnt0, gnt1, done0, done1, byte_rd, nlp} !== 6'b0) begin
            bad++; $display("FAIL midrst_pulses: got=%b exp=000000", {gnt0, gnt1, done0, done1, byte_rd, nlp});
        end
        total++;
        if ({byte_src, enc_valid, enc_last} !== 3'b000 || enc_byte !== 8'h00) begin
            bad++; $display("FAIL midrst_data: got src,valid,last=%b byte=%h exp 000 00", {byte_src, enc_valid, enc_last}, enc_byte);
        end
        @(negedge clk_20mhz);
        rst_i = 1'b0;
        late = 0;
        repeat (300) begin
            @(negedge clk_20mhz);
            if (done0 || done1 || gnt0 || gnt1 || byte_rd) late++;
        end
        total++;
        if (late != 0) begin bad++; $display("FAIL midrst_abandon: got activity cycles=%0d exp=0", late); end
    endtask

    task automatic test_exclusive();
        @(posedge clk_20mhz);
        total++;
        if (n_excl != 0) begin bad++; $display("FAIL exclusive: got overlap cycles=%0d exp=0", n_excl); end
    endtask

    initial begin
        rst_i = 1'b1; req0 = 1'b0; req1 = 1'b0; len0 = 11'd0; len1 = 11'd0;
        test_reset();
        test_nlp_period();
        test_nlp_priority();
        test_zero_len();
        test_basic();
        test_rr();
        test_maxlen_reset();
        test_exclusive();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
